exception_sequencer: RTL

Sequences precise exception and ERET entry for the MIPS core. It sits between the pipeline's exception sources and CP0. It prioritises simultaneous requests and latches the winning cause. It then drives a fixed pipeline hold/flush/commit/redirect sequence that updates CP0 (EPC, Cause, BadVAddr, Status.EXL) and steers fetch to the exception vector or back to EPC.

---
 rtl/exception_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/exception_sequencer.sv
// Precise exception / ERET sequencer: prioritises exception sources, latches the
// winning cause and drives the hold/flush/commit/redirect sequence towards CP0 and fetch.
module exception_sequencer #(
  parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
  parameter logic [31:0] REFILL_VECTOR = 32'h8000_0000,
  parameter int unsigned FLUSH_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_pause_i,
  input  logic        exc_addr_error_i,
  input  logic        exc_tlb_refill_i,
  input  logic        exc_tlb_invalid_i,
  input  logic        exc_tlb_mod_i,
  input  logic        exc_syscall_i,
  input  logic        exc_rw_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] bad_vaddr_i,
  input  logic [5:0]  int_pending_i,
  input  logic        status_ie_i,
  input  logic        status_exl_i,
  input  logic        instr_eret_i,
  input  logic [31:0] epc_i,
  output logic        pipe_hold_o,
  output logic        flush_o,
  output logic        cp0_commit_o,
  output logic [4:0]  cp0_exc_code_o,
  output logic [31:0] cp0_epc_o,
  output logic        cp0_epc_wen_o,
  output logic        cp0_badvaddr_wen_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic        cp0_exl_set_o,
  output logic        cp0_exl_clr_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMMIT   = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_ERET     = 3'd4
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [4:0]  code_r, code_s;
  logic [31:0] epc_r, epc_s;
  logic [31:0] badv_r, badv_s;
  logic        exl_r, exl_s;
  logic        refill_r, refill_s;
  logic        badv_cause_r, badv_cause_s;

  logic        int_req_s, any_req_s, req_badv_s;
  logic [4:0]  req_code_s;

  logic        hold_s, flush_s, commit_s, epc_wen_s, badv_wen_s;
  logic        exl_set_s, exl_clr_s, redirect_s;
  logic [31:0] target_s;
  logic        hold_r, flush_r, commit_r, epc_wen_r, badv_wen_r;
  logic        exl_set_r, exl_clr_r, redirect_r;
  logic [31:0] target_r;

  // Qualify interrupts and encode the highest-priority pending cause.
  always_comb begin
    int_req_s  = (|int_pending_i) & status_ie_i & ~status_exl_i;
    any_req_s  = exc_addr_error_i | exc_tlb_refill_i | exc_tlb_invalid_i |
                 exc_tlb_mod_i | exc_syscall_i | int_req_s;
    req_code_s = 5'd0;
    req_badv_s = 1'b0;
    if (exc_addr_error_i) begin
      req_code_s = exc_rw_i ? 5'd5 : 5'd4;
      req_badv_s = 1'b1;
    end else if (exc_tlb_refill_i | exc_tlb_invalid_i) begin
      req_code_s = exc_rw_i ? 5'd3 : 5'd2;
      req_badv_s = 1'b1;
    end else if (exc_tlb_mod_i) begin
      req_code_s = 5'd1;
      req_badv_s = 1'b1;
    end else if (exc_syscall_i) begin
      req_code_s = 5'd8;
      req_badv_s = 1'b0;
    end else begin
      req_code_s = 5'd0;
      req_badv_s = 1'b0;
    end
  end

  // Next state, flush counter and cause latches.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    code_s       = code_r;
    epc_s        = epc_r;
    badv_s       = badv_r;
    exl_s        = exl_r;
    refill_s     = refill_r;
    badv_cause_s = badv_cause_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s      = ST_COMMIT;
          code_s       = req_code_s;
          epc_s        = exc_pc_i;
          badv_s       = bad_vaddr_i;
          exl_s        = status_exl_i;
          // refill only steers the vector when it is the winning cause
          refill_s     = exc_tlb_refill_i & ~exc_addr_error_i;
          badv_cause_s = req_badv_s;
        end else if (instr_eret_i) begin
          state_s = ST_ERET;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_s = ST_FLUSH;
        cnt_s   = FLUSH_LOAD;
      end
      ST_FLUSH: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_REDIRECT;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_REDIRECT: state_s = ST_IDLE;
      ST_ERET:     state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the strobes come straight from flops.
  always_comb begin
    hold_s     = 1'b0;
    flush_s    = 1'b0;
    commit_s   = 1'b0;
    epc_wen_s  = 1'b0;
    badv_wen_s = 1'b0;
    exl_set_s  = 1'b0;
    exl_clr_s  = 1'b0;
    redirect_s = 1'b0;
    target_s   = 32'h0000_0000;
    case (state_s)
      ST_COMMIT: begin
        hold_s     = 1'b1;
        flush_s    = 1'b1;
        commit_s   = 1'b1;
        exl_set_s  = 1'b1;
        epc_wen_s  = ~exl_s;
        badv_wen_s = badv_cause_s;
      end
      ST_FLUSH: begin
        hold_s  = 1'b1;
        flush_s = 1'b1;
      end
      ST_REDIRECT: begin
        hold_s     = 1'b1;
        redirect_s = 1'b1;
        target_s   = (refill_s & ~exl_s) ? REFILL_VECTOR : EXC_VECTOR;
      end
      ST_ERET: begin
        hold_s     = 1'b1;
        flush_s    = 1'b1;
        exl_clr_s  = 1'b1;
        redirect_s = 1'b1;
        target_s   = epc_i;
      end
      ST_IDLE: hold_s = 1'b0;
      default: hold_s = 1'b0;
    endcase
  end

  // State, latches and output registers; a pause freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      code_r       <= 5'd0;
      epc_r        <= 32'h0000_0000;
      badv_r       <= 32'h0000_0000;
      exl_r        <= 1'b0;
      refill_r     <= 1'b0;
      badv_cause_r <= 1'b0;
      hold_r       <= 1'b0;
      flush_r      <= 1'b0;
      commit_r     <= 1'b0;
      epc_wen_r    <= 1'b0;
      badv_wen_r   <= 1'b0;
      exl_set_r    <= 1'b0;
      exl_clr_r    <= 1'b0;
      redirect_r   <= 1'b0;
      target_r     <= 32'h0000_0000;
    end else if (!cpu_pause_i) begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      code_r       <= code_s;
      epc_r        <= epc_s;
      badv_r       <= badv_s;
      exl_r        <= exl_s;
      refill_r     <= refill_s;
      badv_cause_r <= badv_cause_s;
      hold_r       <= hold_s;
      flush_r      <= flush_s;
      commit_r     <= commit_s;
      epc_wen_r    <= epc_wen_s;
      badv_wen_r   <= badv_wen_s;
      exl_set_r    <= exl_set_s;
      exl_clr_r    <= exl_clr_s;
      redirect_r   <= redirect_s;
      target_r     <= target_s;
    end
  end

  assign pipe_hold_o        = hold_r;
  assign flush_o            = flush_r;
  assign cp0_commit_o       = commit_r;
  assign cp0_exc_code_o     = code_r;
  assign cp0_epc_o          = epc_r;
  assign cp0_epc_wen_o      = epc_wen_r;
  assign cp0_badvaddr_wen_o = badv_wen_r;
  assign cp0_badvaddr_o     = badv_r;
  assign cp0_exl_set_o      = exl_set_r;
  assign cp0_exl_clr_o      = exl_clr_r;
  assign pc_redirect_o      = redirect_r;
  assign pc_target_o        = target_r;

endmodule
